check: RTL and testbench
========================

Name: check

Overview:
- Consumer end of the stimulus pipeline.
- Pops expected-result records from CHECK_FIFO and sampled DUT outputs from RESULT_FIFO, compares them under the active output bitmask, and writes a 2-word result record back to memory over an Avalon-MM write master.
- Acts as responder on the STIM<=>CHECK command interface (bitmask setup, counter clear) and keeps pass/fail statistics.

Parameters:
ADDR_WIDTH, 20, memory word address width
DATA_WIDTH, 16, memory data width
BE_WIDTH, DATA_WIDTH/8, byte-enable width
STF_WIDTH, 24, test/result vector width
ORV_WIDTH, 8, OR-value (status seed) width
CHF_WIDTH, STF_WIDTH+ORV_WIDTH+ADDR_WIDTH, CHECK_FIFO word: {expected, address, orv} MSB→LSB
SCC_WIDTH, 5, command code width
SCD_WIDTH, 24, command data width
CNT_WIDTH, 16, statistics counter width

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
cfifo_q  in  CHF_WIDTH  CHECK_FIFO show-ahead head word
cfifo_rdreq  out  1  CHECK_FIFO pop (comb)
cfifo_rdempty  in  1  CHECK_FIFO empty
rfifo_q  in  STF_WIDTH  RESULT_FIFO show-ahead head (actual DUT outputs)
rfifo_rdreq  out  1  RESULT_FIFO pop (comb)
rfifo_rdempty  in  1  RESULT_FIFO empty
mem_address  out  ADDR_WIDTH  write address
mem_byteenable  out  BE_WIDTH  constant all ones
mem_write  out  1  write strobe (comb)
mem_writedata  out  DATA_WIDTH  write data
mem_waitrequest  in  1  slave stall
sc_cmd  in  SCC_WIDTH  command: 00000 IDLE, 00001 BITMASK, 00010 CLRCNT
sc_data  in  SCD_WIDTH  command payload
sc_switching  in  1  stim is switching target/Vdd
sc_ready  out  1  command accept (comb)
vec_count  out  CNT_WIDTH  vectors checked
fail_count  out  CNT_WIDTH  vectors failed

Behaviour:
- Reset: state IDLE; bitmask all ones; vec_count = fail_count = 0; latched regs 0.
- Reset mid-write aborts immediately: mem_write drops, record lost, FIFOs untouched.
- Comb outputs at reset: mem_write 0, rdreqs 0, sc_ready 1 if cfifo_rdempty.
- sc_ready = state==IDLE && cfifo_rdempty.
  - Commands apply only after all queued vectors are checked.
  - BITMASK: mask <= sc_data[STF_WIDTH-1:0] on the cycle sc_ready && sc_cmd==BITMASK.
  - CLRCNT: both counters <= 0 on the same acceptance condition.
  - Other codes are ignored.
  - Command acceptance and a FIFO pop cannot coincide, because sc_ready requires cfifo empty.
- FSM:
  - IDLE:
    - Leaves only when ~cfifo_rdempty && ~rfifo_rdempty && ~sc_switching.
    - That cycle: both rdreq asserted together, exactly 1 cycle.
    - Latch exp, addr, orv from cfifo_q and act from rfifo_q.
    - Next state COMPARE.
    - If only one FIFO is non-empty, wait; never pop one FIFO alone.
  - COMPARE:
    - fail <= |((act ^ exp) & mask).
    - status <= orv | {0…, fail}.
    - vec_count += 1; fail_count += fail. Both saturate at all ones.
    - Next state WR_HI.
  - WR_HI:
    - mem_write=1, mem_address=addr, mem_writedata={status, act[23:16]}.
    - Hold all outputs stable while mem_waitrequest is high.
    - Advance to WR_LO when ~mem_waitrequest.
  - WR_LO:
    - mem_address=addr+1 (wraps modulo 2^ADDR_WIDTH), mem_writedata=act[15:0].
    - Go to IDLE when ~mem_waitrequest.
- Latency:
  - Pop to first write strobe: 2 cycles.
  - Minimum record turnaround: 4 cycles (IDLE, COMPARE, WR_HI, WR_LO).
- In WR_*, mem_address/mem_writedata are registered-derived; no glitching while stalled.
- sc_switching high while in COMPARE or WR_*: the current record completes; only new pops are blocked.

Decomposition:
- Shared package: SC_CMD_IDLE/BITMASK/CLRCNT codes; CHF field offsets (expected, address, orv slices); state encodings (3-bit: IDLE, COMPARE, WR_HI, WR_LO).
- The stim block imports the same command codes and field offsets.
- One natural sub-module: check_cmp. Combinational/registered masked compare producing fail and status, reusable for a future per-bit error map.

Test Plan:
- Reset, push cfifo {exp=24'hA5A5A5, addr=20'h00010, orv=0} and rfifo 24'hA5A5A5, no stalls → writes 16'h00A5 @0x00010, then 16'hA5A5 @0x00011; vec_count=1, fail_count=0.
- Same but act=24'hA5A5A4 → word0=16'h01A5; fail_count=1.
- BITMASK sc_data=24'hFFFFFE with FIFOs empty → sc_ready=1, accepted; repeat the mismatch case → status 00, fail_count unchanged.
- Issue BITMASK while 2 records are queued → sc_ready stays 0 until both records are written with the old mask; then the new mask is applied.
- mem_waitrequest high for 5 cycles in WR_HI and 3 cycles in WR_LO → address/data held constant, exactly 2 accepted writes, then IDLE.
- rfifo empty with cfifo full, and sc_switching high with both non-empty → no rdreq. Drop sc_switching → single pop. addr=20'hFFFFF writes the second word to 0x00000. Reset asserted in WR_HI → mem_write=0 next cycle, counters=0.

Source files
------------

// File: rtl/check_pkg.sv
// check_pkg: definitions shared by the stim and check ends of the stimulus
// pipeline.
//   - STIM<=>CHECK command codes
//   - CHECK_FIFO word layout {expected, address, orv}, MSB to LSB
//   - check FSM state encodings
package check_pkg;

  // Default widths of the stimulus pipeline.
  localparam int unsigned CHK_ADDR_WIDTH = 20;
  localparam int unsigned CHK_STF_WIDTH  = 24;
  localparam int unsigned CHK_ORV_WIDTH  = 8;
  localparam int unsigned CHK_CHF_WIDTH  = CHK_STF_WIDTH + CHK_ORV_WIDTH + CHK_ADDR_WIDTH;

  // Command codes on sc_cmd.
  typedef enum logic [4:0] {
    SC_CMD_IDLE    = 5'b00000,
    SC_CMD_BITMASK = 5'b00001,
    SC_CMD_CLRCNT  = 5'b00010
  } sc_cmd_e;

  // Check FSM states.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COMPARE = 3'd1,
    ST_WR_HI   = 3'd2,
    ST_WR_LO   = 3'd3
  } check_state_e;

  // LSB offsets of the CHECK_FIFO fields. orv always sits at bit 0.
  localparam int unsigned CHF_ORV_LSB = 0;

  function automatic int unsigned chf_addr_lsb(input int unsigned orv_w);
    return orv_w;
  endfunction

  function automatic int unsigned chf_exp_lsb(input int unsigned orv_w,
                                              input int unsigned addr_w);
    return orv_w + addr_w;
  endfunction

endpackage

// File: rtl/check_cmp.sv
// check_cmp: masked compare of actual against expected DUT outputs.
//   act, exp - actual and expected vectors
//   mask     - active output bitmask (1 = bit is compared)
//   orv      - status seed from the expected-result record
//   fail     - any masked bit differs
//   status   - orv with fail OR-ed into bit 0
module check_cmp #(
  parameter int unsigned STF_WIDTH = 24,
  parameter int unsigned ORV_WIDTH = 8
) (
  input  logic [STF_WIDTH-1:0] act,
  input  logic [STF_WIDTH-1:0] exp,
  input  logic [STF_WIDTH-1:0] mask,
  input  logic [ORV_WIDTH-1:0] orv,
  output logic                 fail,
  output logic [ORV_WIDTH-1:0] status
);

  always_comb begin
    fail   = |((act ^ exp) & mask);
    status = orv | {{(ORV_WIDTH-1){1'b0}}, fail};
  end

endmodule

// File: rtl/check.sv
// check: consumer end of the stimulus pipeline.
// Pops an expected-result record from CHECK_FIFO together with the sampled DUT
// outputs from RESULT_FIFO, compares them under the active bitmask and writes
// a 2-word result record ({status, act[23:16]} @addr, act[15:0] @addr+1) over
// an Avalon-MM write master. Responds to BITMASK / CLRCNT commands once all
// queued records are checked, and keeps saturating pass/fail counters.
//   clock, reset         - system clock, async active-high reset
//   cfifo_*              - CHECK_FIFO show-ahead read side
//   rfifo_*              - RESULT_FIFO show-ahead read side
//   mem_*                - Avalon-MM write master
//   sc_*                 - STIM<=>CHECK command interface
//   vec_count/fail_count - vectors checked / failed
module check
  import check_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 20,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned STF_WIDTH  = 24,
  parameter int unsigned ORV_WIDTH  = 8,
  parameter int unsigned CHF_WIDTH  = STF_WIDTH + ORV_WIDTH + ADDR_WIDTH,
  parameter int unsigned SCC_WIDTH  = 5,
  parameter int unsigned SCD_WIDTH  = 24,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [CHF_WIDTH-1:0]  cfifo_q,
  output logic                  cfifo_rdreq,
  input  logic                  cfifo_rdempty,
  input  logic [STF_WIDTH-1:0]  rfifo_q,
  output logic                  rfifo_rdreq,
  input  logic                  rfifo_rdempty,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [BE_WIDTH-1:0]   mem_byteenable,
  output logic                  mem_write,
  output logic [DATA_WIDTH-1:0] mem_writedata,
  input  logic                  mem_waitrequest,
  input  logic [SCC_WIDTH-1:0]  sc_cmd,
  input  logic [SCD_WIDTH-1:0]  sc_data,
  input  logic                  sc_switching,
  output logic                  sc_ready,
  output logic [CNT_WIDTH-1:0]  vec_count,
  output logic [CNT_WIDTH-1:0]  fail_count
);

  localparam int unsigned ADDR_LSB = chf_addr_lsb(ORV_WIDTH);
  localparam int unsigned EXP_LSB  = chf_exp_lsb(ORV_WIDTH, ADDR_WIDTH);
  localparam int unsigned HI_ACT_W = DATA_WIDTH - ORV_WIDTH;

  check_state_e          state_q, state_d;
  logic [STF_WIDTH-1:0]  exp_q, act_q, mask_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ORV_WIDTH-1:0]  orv_q, status_q;
  logic [CNT_WIDTH-1:0]  vec_q, fail_q;
  logic                  cmp_fail;
  logic [ORV_WIDTH-1:0]  cmp_status;
  logic                  pop;

  check_cmp #(
    .STF_WIDTH(STF_WIDTH),
    .ORV_WIDTH(ORV_WIDTH)
  ) u_cmp (
    .act   (act_q),
    .exp   (exp_q),
    .mask  (mask_q),
    .orv   (orv_q),
    .fail  (cmp_fail),
    .status(cmp_status)
  );

  // Both FIFOs are popped together or not at all; held off during reset.
  assign pop = (state_q == ST_IDLE) && !cfifo_rdempty && !rfifo_rdempty &&
               !sc_switching && !reset;

  // Commands are only taken once every queued record has been checked.
  assign sc_ready       = (state_q == ST_IDLE) && cfifo_rdempty;
  assign mem_byteenable = '1;
  assign vec_count      = vec_q;
  assign fail_count     = fail_q;

  always_comb begin
    state_d       = state_q;
    cfifo_rdreq   = 1'b0;
    rfifo_rdreq   = 1'b0;
    mem_write     = 1'b0;
    mem_address   = addr_q;
    mem_writedata = {status_q, act_q[STF_WIDTH-1 -: HI_ACT_W]};
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          cfifo_rdreq = 1'b1;
          rfifo_rdreq = 1'b1;
          state_d     = ST_COMPARE;
        end
      end
      ST_COMPARE: state_d = ST_WR_HI;
      ST_WR_HI: begin
        mem_write = 1'b1;
        if (!mem_waitrequest) state_d = ST_WR_LO;
      end
      ST_WR_LO: begin
        mem_write     = 1'b1;
        mem_address   = addr_q + ADDR_WIDTH'(1);
        mem_writedata = act_q[DATA_WIDTH-1:0];
        if (!mem_waitrequest) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      exp_q    <= '0;
      act_q    <= '0;
      addr_q   <= '0;
      orv_q    <= '0;
      status_q <= '0;
      mask_q   <= '1;
      vec_q    <= '0;
      fail_q   <= '0;
    end else begin
      state_q <= state_d;
      if (pop) begin
        exp_q  <= cfifo_q[EXP_LSB +: STF_WIDTH];
        addr_q <= cfifo_q[ADDR_LSB +: ADDR_WIDTH];
        orv_q  <= cfifo_q[CHF_ORV_LSB +: ORV_WIDTH];
        act_q  <= rfifo_q;
      end
      if (state_q == ST_COMPARE) begin
        status_q <= cmp_status;
        if (vec_q != '1) vec_q <= vec_q + CNT_WIDTH'(1);
        if (cmp_fail && fail_q != '1) fail_q <= fail_q + CNT_WIDTH'(1);
      end
      // sc_ready implies IDLE, so this never meets the COMPARE update above.
      if (sc_ready && sc_cmd == SC_CMD_BITMASK) mask_q <= sc_data[STF_WIDTH-1:0];
      if (sc_ready && sc_cmd == SC_CMD_CLRCNT) begin
        vec_q  <= '0;
        fail_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_check.sv
// tb_check: directed bench for check. FIFOs are modelled as queues with a
// show-ahead head; memory writes accepted by the slave are logged in order.
module tb_check;
  import check_pkg::*;

  localparam int unsigned AW  = 20;
  localparam int unsigned DW  = 16;
  localparam int unsigned SW  = 24;
  localparam int unsigned OW  = 8;
  localparam int unsigned CW  = SW + OW + AW;
  localparam int unsigned NW  = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [CW-1:0] cfifo_q = '0;
  logic          cfifo_rdreq;
  logic          cfifo_rdempty = 1'b1;
  logic [SW-1:0] rfifo_q = '0;
  logic          rfifo_rdreq;
  logic          rfifo_rdempty = 1'b1;
  logic [AW-1:0] mem_address;
  logic [DW/8-1:0] mem_byteenable;
  logic          mem_write;
  logic [DW-1:0] mem_writedata;
  logic          mem_waitrequest = 1'b0;
  logic [4:0]    sc_cmd = SC_CMD_IDLE;
  logic [23:0]   sc_data = '0;
  logic          sc_switching = 1'b0;
  logic          sc_ready;
  logic [NW-1:0] vec_count, fail_count;

  logic [CW-1:0] cq[$];
  logic [SW-1:0] rq[$];
  logic [AW-1:0] wa[$];
  logic [DW-1:0] wd[$];
  int pops_c = 0, pops_r = 0, pop_skew = 0;
  int checks = 0, failures = 0;

  check #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(DW/8), .STF_WIDTH(SW),
    .ORV_WIDTH(OW), .CHF_WIDTH(CW), .SCC_WIDTH(5), .SCD_WIDTH(24), .CNT_WIDTH(NW)
  ) dut (
    .clock(clock), .reset(reset),
    .cfifo_q(cfifo_q), .cfifo_rdreq(cfifo_rdreq), .cfifo_rdempty(cfifo_rdempty),
    .rfifo_q(rfifo_q), .rfifo_rdreq(rfifo_rdreq), .rfifo_rdempty(rfifo_rdempty),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_write(mem_write), .mem_writedata(mem_writedata),
    .mem_waitrequest(mem_waitrequest),
    .sc_cmd(sc_cmd), .sc_data(sc_data), .sc_switching(sc_switching),
    .sc_ready(sc_ready), .vec_count(vec_count), .fail_count(fail_count)
  );

  always #5 clock = ~clock;

  // FIFO read side and write-slave logger. Strobes are sampled at the edge,
  // FIFO heads/flags move 1ns later.
  always @(posedge clock) begin : fifo_model
    logic pc, pr;
    logic [CW-1:0] dc;
    logic [SW-1:0] dr;
    pc = cfifo_rdreq;
    pr = rfifo_rdreq;
    if (mem_write && !mem_waitrequest && !reset) begin
      wa.push_back(mem_address);
      wd.push_back(mem_writedata);
    end
    #1;
    if (pc != pr) pop_skew++;
    if (pc && cq.size() > 0) begin dc = cq.pop_front(); pops_c++; end
    if (pr && rq.size() > 0) begin dr = rq.pop_front(); pops_r++; end
    cfifo_rdempty = (cq.size() == 0);
    cfifo_q       = (cq.size() == 0) ? '0 : cq[0];
    rfifo_rdempty = (rq.size() == 0);
    rfifo_q       = (rq.size() == 0) ? '0 : rq[0];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s mismatch", tag);
    end
  endtask

  task automatic push_rec(input logic [SW-1:0] e, input logic [AW-1:0] a,
                          input logic [OW-1:0] o, input logic [SW-1:0] act);
    cq.push_back({e, a, o});
    rq.push_back(act);
  endtask

  task automatic wait_writes(input int n);
    int k;
    k = 0;
    while (wa.size() < n && k < 80) begin
      @(negedge clock);
      k++;
    end
    chk("write_wait", 64'(wa.size() >= n), 64'd1);
  endtask

  task automatic chk_write(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    chk($sformatf("wr%0d_addr", i), (i < wa.size()) ? 64'(wa[i]) : 'x, 64'(a));
    chk($sformatf("wr%0d_data", i), (i < wd.size()) ? 64'(wd[i]) : 'x, 64'(d));
  endtask

  initial begin
    int k, p0, base, busy;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_cfifo_rdreq", 64'(cfifo_rdreq), 64'd0);
    chk("rst_rfifo_rdreq", 64'(rfifo_rdreq), 64'd0);
    chk("rst_sc_ready", 64'(sc_ready), 64'd1);
    chk("rst_byteenable", 64'(mem_byteenable), 64'h3);
    reset = 1'b0;
    @(negedge clock);
    chk("rst_vec_count", 64'(vec_count), 64'd0);
    chk("rst_fail_count", 64'(fail_count), 64'd0);

    // Matching record
    push_rec(24'hA5A5A5, 20'h00010, 8'h00, 24'hA5A5A5);
    wait_writes(2);
    chk_write(0, 20'h00010, 16'h00A5);
    chk_write(1, 20'h00011, 16'hA5A5);
    chk("t1_vec", 64'(vec_count), 64'd1);
    chk("t1_fail", 64'(fail_count), 64'd0);

    // LSB mismatch
    push_rec(24'hA5A5A5, 20'h00012, 8'h00, 24'hA5A5A4);
    wait_writes(4);
    chk_write(2, 20'h00012, 16'h01A5);
    chk_write(3, 20'h00013, 16'hA5A4);
    chk("t2_vec", 64'(vec_count), 64'd2);
    chk("t2_fail", 64'(fail_count), 64'd1);

    // Mask off bit 0, repeat the mismatch
    @(negedge clock);
    chk("t3_sc_ready", 64'(sc_ready), 64'd1);
    sc_cmd = SC_CMD_BITMASK; sc_data = 24'hFFFFFE;
    @(negedge clock);
    sc_cmd = SC_CMD_IDLE;
    push_rec(24'hA5A5A5, 20'h00014, 8'h00, 24'hA5A5A4);
    wait_writes(6);
    chk_write(4, 20'h00014, 16'h00A5);
    chk_write(5, 20'h00015, 16'hA5A4);
    chk("t3_vec", 64'(vec_count), 64'd3);
    chk("t3_fail", 64'(fail_count), 64'd1);

    // BITMASK issued with two records queued: held until both are written
    push_rec(24'hA5A5A5, 20'h00020, 8'h00, 24'hA5A5A4);
    push_rec(24'hA5A5A5, 20'h00030, 8'h00, 24'hA5A5A4);
    @(negedge clock);
    sc_cmd = SC_CMD_BITMASK; sc_data = 24'hFFFFFF;
    busy = 0; k = 0;
    while (wa.size() < 10 && k < 80) begin
      if (sc_ready) busy++;
      @(negedge clock);
      k++;
    end
    chk("t4_ready_held", 64'(busy), 64'd0);
    chk("t4_ready_after", 64'(sc_ready), 64'd1);
    @(negedge clock);
    sc_cmd = SC_CMD_IDLE;
    chk_write(6, 20'h00020, 16'h00A5);
    chk_write(7, 20'h00021, 16'hA5A4);
    chk_write(8, 20'h00030, 16'h00A5);
    chk_write(9, 20'h00031, 16'hA5A4);
    chk("t4_fail_old_mask", 64'(fail_count), 64'd1);
    push_rec(24'hA5A5A5, 20'h00034, 8'h00, 24'hA5A5A4);
    wait_writes(12);
    chk_write(10, 20'h00034, 16'h01A5);
    chk_write(11, 20'h00035, 16'hA5A4);
    chk("t4_vec", 64'(vec_count), 64'd6);
    chk("t4_fail", 64'(fail_count), 64'd2);

    // Slave stall: 5 cycles in WR_HI, 3 in WR_LO
    mem_waitrequest = 1'b1;
    base = wa.size();
    push_rec(24'h123456, 20'h00040, 8'h00, 24'h123456);
    k = 0;
    while (!mem_write && k < 20) begin @(negedge clock); k++; end
    chk("t5_hi_addr", 64'(mem_address), 64'h40);
    chk("t5_hi_data", 64'(mem_writedata), 64'h0012);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clock);
      chk("t5_hi_hold_addr", 64'(mem_address), 64'h40);
      chk("t5_hi_hold_data", 64'(mem_writedata), 64'h0012);
      chk("t5_hi_hold_write", 64'(mem_write), 64'd1);
    end
    mem_waitrequest = 1'b0;
    @(negedge clock);
    mem_waitrequest = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      chk("t5_lo_hold_addr", 64'(mem_address), 64'h41);
      chk("t5_lo_hold_data", 64'(mem_writedata), 64'h3456);
      @(negedge clock);
    end
    mem_waitrequest = 1'b0;
    repeat (3) @(negedge clock);
    chk("t5_write_count", 64'(wa.size() - base), 64'd2);
    chk_write(base, 20'h00040, 16'h0012);
    chk_write(base + 1, 20'h00041, 16'h3456);
    chk("t5_idle", 64'(sc_ready), 64'd1);
    chk("t5_vec", 64'(vec_count), 64'd7);

    // Pop gating: rfifo empty, then sc_switching; address wrap
    p0 = pops_c;
    base = wa.size();
    cq.push_back({24'hA5A5A5, 20'hFFFFF, 8'h80});
    repeat (6) @(negedge clock);
    chk("t6_no_pop_rempty", 64'(pops_c + pops_r), 64'(2 * p0));
    chk("t6_ready_busy", 64'(sc_ready), 64'd0);
    sc_switching = 1'b1;
    rq.push_back(24'h5A5A5A);
    repeat (6) @(negedge clock);
    chk("t6_no_pop_switch", 64'(pops_c + pops_r), 64'(2 * p0));
    sc_switching = 1'b0;
    wait_writes(base + 2);
    chk("t6_single_pop_c", 64'(pops_c), 64'(p0 + 1));
    chk("t6_single_pop_r", 64'(pops_r), 64'(p0 + 1));
    chk_write(base, 20'hFFFFF, 16'h815A);
    chk_write(base + 1, 20'h00000, 16'h5A5A);
    chk("t6_vec", 64'(vec_count), 64'd8);
    chk("t6_fail", 64'(fail_count), 64'd3);

    // Counter clear
    @(negedge clock);
    sc_cmd = SC_CMD_CLRCNT;
    @(negedge clock);
    sc_cmd = SC_CMD_IDLE;
    chk("clr_vec", 64'(vec_count), 64'd0);
    chk("clr_fail", 64'(fail_count), 64'd0);

    // Reset while stalled in WR_HI
    mem_waitrequest = 1'b1;
    base = wa.size();
    push_rec(24'hA5A5A5, 20'h00050, 8'h00, 24'hA5A5A5);
    k = 0;
    while (!mem_write && k < 20) begin @(negedge clock); k++; end
    chk("t7_in_wr_hi", 64'(mem_write), 64'd1);
    chk("t7_vec_pre", 64'(vec_count), 64'd1);
    reset = 1'b1;
    #1;
    chk("t7_rst_write", 64'(mem_write), 64'd0);
    chk("t7_rst_vec", 64'(vec_count), 64'd0);
    chk("t7_rst_fail", 64'(fail_count), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    mem_waitrequest = 1'b0;
    repeat (2) @(negedge clock);
    chk("t7_no_write", 64'(wa.size()), 64'(base));

    // Mask back to all ones after reset
    push_rec(24'hA5A5A5, 20'h00060, 8'h00, 24'hA5A5A4);
    wait_writes(base + 2);
    chk_write(base, 20'h00060, 16'h01A5);
    chk_write(base + 1, 20'h00061, 16'hA5A4);
    chk("t7_vec", 64'(vec_count), 64'd1);
    chk("t7_fail", 64'(fail_count), 64'd1);

    chk("pop_together", 64'(pop_skew), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
